// File: rtl/ifft32_iter_engine_if.sv
// Frame handshake and packed int8 sample buses for the iterative 32-point IFFT engine.
interface ifft32_iter_engine_if;
  logic         start;
  logic [255:0] Xk_vect_real;
  logic [255:0] Xk_vect_imag;
  logic         busy;
  logic         done;
  logic [255:0] xn_vect_real;
  logic [255:0] xn_vect_imag;

  modport master (
    output start, Xk_vect_real, Xk_vect_imag,
    input  busy, done, xn_vect_real, xn_vect_imag
  );

  modport slave (
    input  start, Xk_vect_real, Xk_vect_imag,
    output busy, done, xn_vect_real, xn_vect_imag
  );
endinterface

// File: rtl/ifft32_iter_engine.sv
// Iterative 32-point radix-2 DIT inverse FFT: one shared butterfly working in place
// over a 32-entry complex register file, 1/32 scaling applied once at the output.
module ifft32_iter_engine #(
  parameter int unsigned IW = 16,
  parameter int unsigned TW = 16
) (
  input logic                clk1,
  input logic                rst,
  ifft32_iter_engine_if.slave bus
);
  localparam int unsigned FRAC = TW - 2;
  localparam int unsigned PW   = IW + TW + 2;
  localparam int          RND  = 1 << (FRAC - 1);

  // exp(+j*2*pi*m/32) in Q2.14, m = 0..15
  localparam int COS_Q14 [16] = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196,
                                  0, -3196, -6270, -9102, -11585, -13623, -15137, -16069};
  localparam int SIN_Q14 [16] = '{0, 3196, 6270, 9102, 11585, 13623, 15137, 16069,
                                  16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196};

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

  state_t state_q, state_nx;
  logic   acc_en, ld_en, bf_en, out_en;
  logic   last_bf;

  logic [2:0]   s_q;
  logic [3:0]   b_q;
  logic [255:0] xr_q, xi_q;
  logic         busy_q, done_q;
  logic [255:0] xr_out_q, xi_out_q;

  logic signed [IW-1:0] ram_re [32];
  logic signed [IW-1:0] ram_im [32];

  logic [4:0] b_ext, lo_mask, idx_a, idx_p;
  logic [3:0] tw_m;
  logic signed [TW-1:0] w_re, w_im;
  logic signed [IW-1:0] a_re, a_im, p_re, p_im, t_re, t_im;
  logic signed [PW-1:0] prod_re, prod_im;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // Round half up by 1/32 and clamp to int8
  function automatic logic [7:0] to_out(input logic signed [IW-1:0] v);
    logic signed [IW:0] r;
    r = (IW+1)'(v) + (IW+1)'(16);
    r = r >>> 5;
    if (r > (IW+1)'(127))       return 8'h7F;
    else if (r < (IW+1)'(-128)) return 8'h80;
    else                        return r[7:0];
  endfunction

  assign last_bf = (s_q == 3'd4) && (b_q == 4'd15);

  always_ff @(posedge clk1) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    acc_en   = 1'b0;
    ld_en    = 1'b0;
    bf_en    = 1'b0;
    out_en   = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        acc_en   = 1'b1;
        state_nx = LOAD;
      end
      LOAD: begin
        ld_en    = 1'b1;
        state_nx = CALC;
      end
      CALC: begin
        bf_en = 1'b1;
        if (last_bf) state_nx = OUT;
      end
      OUT: begin
        out_en   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage / butterfly counters
  always_ff @(posedge clk1) begin
    if (!rst || ld_en) begin
      s_q <= 3'd0;
      b_q <= 4'd0;
    end else if (bf_en) begin
      b_q <= b_q + 4'd1;
      if (b_q == 4'd15) s_q <= s_q + 3'd1;
    end
  end

  always_ff @(posedge clk1) begin
    if (acc_en) begin
      xr_q <= bus.Xk_vect_real;
      xi_q <= bus.Xk_vect_imag;
    end
  end

  // Butterfly addressing and twiddle selection for stage s_q, butterfly b_q
  always_comb begin
    b_ext   = {1'b0, b_q};
    lo_mask = (5'd1 << s_q) - 5'd1;
    idx_a   = 5'(((b_ext >> s_q) << (s_q + 3'd1)) | (b_ext & lo_mask));
    idx_p   = idx_a | (5'd1 << s_q);
    tw_m    = 4'((b_ext & lo_mask) << (3'd4 - s_q));
    w_re    = TW'(COS_Q14[tw_m]);
    w_im    = TW'(SIN_Q14[tw_m]);
  end

  always_comb begin
    a_re    = ram_re[idx_a];
    a_im    = ram_im[idx_a];
    p_re    = ram_re[idx_p];
    p_im    = ram_im[idx_p];
    prod_re = PW'(p_re) * PW'(w_re) - PW'(p_im) * PW'(w_im) + PW'(RND);
    prod_im = PW'(p_re) * PW'(w_im) + PW'(p_im) * PW'(w_re) + PW'(RND);
    t_re    = IW'(prod_re >>> FRAC);
    t_im    = IW'(prod_im >>> FRAC);
  end

  // Working store: bit-reversed load, then in-place butterflies
  always_ff @(posedge clk1) begin
    if (ld_en) begin
      for (int k = 0; k < 32; k++) begin
        ram_re[k] <= IW'($signed(xr_q[8*bitrev5(5'(k)) +: 8]));
        ram_im[k] <= IW'($signed(xi_q[8*bitrev5(5'(k)) +: 8]));
      end
    end else if (bf_en) begin
      ram_re[idx_a] <= a_re + t_re;
      ram_im[idx_a] <= a_im + t_im;
      ram_re[idx_p] <= a_re - t_re;
      ram_im[idx_p] <= a_im - t_im;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      xr_out_q <= '0;
      xi_out_q <= '0;
    end else begin
      done_q <= out_en;
      if (acc_en)      busy_q <= 1'b1;
      else if (out_en) busy_q <= 1'b0;
      if (out_en) begin
        for (int n = 0; n < 32; n++) begin
          xr_out_q[8*n +: 8] <= to_out(ram_re[n]);
          xi_out_q[8*n +: 8] <= to_out(ram_im[n]);
        end
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.xn_vect_real = xr_out_q;
  assign bus.xn_vect_imag = xi_out_q;
endmodule

// File: tb/tb_ifft32_iter_engine.sv
// Self-checking bench for ifft32_iter_engine: directed vector table, handshake/reset
// sequences and random frames against a floating-point inverse DFT.
module tb_ifft32_iter_engine;
  logic clk1 = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  ifft32_iter_engine_if bus ();
  ifft32_iter_engine dut (.clk1(clk1), .rst(rst), .bus(bus.slave));

  always #5 clk1 = ~clk1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [255:0] xr, xi, er, ei, mask;
  } vec_t;

  vec_t vecs [7];
  real  cos_t [32];
  real  sin_t [32];

  function automatic logic [255:0] set_b(input logic [255:0] v, input int i, input int val);
    logic [255:0] r;
    r = v;
    r[8*i +: 8] = 8'(val);
    return r;
  endfunction

  function automatic int comp(input logic [255:0] v, input int n);
    return int'($signed(v[8*n +: 8]));
  endfunction

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp,
                         input logic [255:0] mask);
    n_cmp++;
    if ((act & mask) !== (exp & mask)) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (mask %h)", name, act & mask, exp & mask, mask);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Issue one frame (start accepted at the next edge), scramble inputs, wait for done.
  task automatic run_frame(input logic [255:0] xr, input logic [255:0] xi, output int lat);
    bus.Xk_vect_real = xr;
    bus.Xk_vect_imag = xi;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.Xk_vect_real = {8{$urandom}};
    bus.Xk_vect_imag = {8{$urandom}};
    chk_int("busy_after_accept", int'(bus.busy), 1);
    lat = -1;
    for (int c = 1; c <= 120; c++) begin
      tick();
      if (bus.done) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int           lat, dcount, d1, d2, bad_n;
    logic [255:0] dc_x, dc_e, bin_m, rr, ri;
    int           sa_re [8];
    int           sa_im [8];
    real          ref_re, ref_im, gr, gi;

    sa_re = '{127, 127, 0, -127, -127, -127, 0, 127};
    sa_im = '{0, -127, -127, -127, 0, 127, 127, 127};
    for (int i = 0; i < 32; i++) begin
      cos_t[i] = $cos(2.0 * 3.141592653589793 * real'(i) / 32.0);
      sin_t[i] = $sin(2.0 * 3.141592653589793 * real'(i) / 32.0);
    end

    dc_x  = set_b('0, 0, 32);
    dc_e  = '0;
    for (int i = 0; i < 32; i++) dc_e = set_b(dc_e, i, 1);
    bin_m = set_b(set_b(set_b(set_b('0, 0, 255), 8, 255), 16, 255), 24, 255);

    // zero frame
    vecs[0] = '{xr: '0, xi: '0, er: '0, ei: '0, mask: '1};
    // DC: every x[n] = 1
    vecs[1] = '{xr: dc_x, xi: '0, er: dc_e, ei: '0, mask: '1};
    // bin +1: x[n] = exp(+j2pi n/32)
    vecs[2] = '{xr: set_b('0, 1, 32), xi: '0,
                er: set_b(set_b('0, 0, 1), 16, -1), ei: set_b(set_b('0, 8, 1), 24, -1), mask: bin_m};
    // bin 31 (=-1): x[n] = exp(-j2pi n/32)
    vecs[3] = '{xr: set_b('0, 31, 32), xi: '0,
                er: set_b(set_b('0, 0, 1), 16, -1), ei: set_b(set_b('0, 8, -1), 24, 1), mask: bin_m};
    // all -128: x[0] = -128, rest 0
    vecs[4] = '{xr: '1, xi: '0, er: set_b('0, 0, -128), ei: '0, mask: '1};
    vecs[4].xr = '0;
    for (int i = 0; i < 32; i++) vecs[4].xr = set_b(vecs[4].xr, i, -128);
    // x[4] real ideally +153 / -153: clamps to 127 / -128, imag 0
    vecs[5] = '{xr: '0, xi: '0, er: set_b('0, 4, 127), ei: '0, mask: set_b('0, 4, 255)};
    vecs[6] = '{xr: '0, xi: '0, er: set_b('0, 4, -128), ei: '0, mask: set_b('0, 4, 255)};
    for (int k = 0; k < 32; k++) begin
      vecs[5].xr = set_b(vecs[5].xr, k, sa_re[k % 8]);
      vecs[5].xi = set_b(vecs[5].xi, k, sa_im[k % 8]);
      vecs[6].xr = set_b(vecs[6].xr, k, -sa_re[k % 8]);
      vecs[6].xi = set_b(vecs[6].xi, k, -sa_im[k % 8]);
    end

    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.Xk_vect_real = '0;
    bus.Xk_vect_imag = '0;
    repeat (3) tick();
    chk_int("reset_busy", int'(bus.busy), 0);
    chk_int("reset_done", int'(bus.done), 0);
    chk_vec("reset_xr", bus.xn_vect_real, '0, '1);
    chk_vec("reset_xi", bus.xn_vect_imag, '0, '1);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].xr, vecs[i].xi, lat);
      chk_int($sformatf("vec%0d_latency", i), lat, 82);
      chk_int($sformatf("vec%0d_busy_at_done", i), int'(bus.busy), 0);
      chk_vec($sformatf("vec%0d_real", i), bus.xn_vect_real, vecs[i].er, vecs[i].mask);
      chk_vec($sformatf("vec%0d_imag", i), bus.xn_vect_imag, vecs[i].ei, vecs[i].mask);
    end
    tick();
    chk_int("done_one_cycle", int'(bus.done), 0);
    chk_vec("outputs_held", bus.xn_vect_real, vecs[6].er, vecs[6].mask);

    // start held for 90 edges: frames finish at E82 and E165
    bus.Xk_vect_real = dc_x;
    bus.Xk_vect_imag = '0;
    bus.start        = 1'b1;
    tick();
    dcount = 0; d1 = -1; d2 = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 89) bus.start = 1'b0;
      if (bus.done) begin
        dcount++;
        if (dcount == 1) d1 = k;
        else if (dcount == 2) d2 = k;
      end
      if (k == 81) chk_int("held_busy_e81", int'(bus.busy), 1);
      if (k == 82) chk_int("held_busy_e82", int'(bus.busy), 0);
      if (k == 83) chk_int("held_busy_e83", int'(bus.busy), 1);
      if (k == 83) chk_int("held_done_e83", int'(bus.done), 0);
    end
    chk_int("held_done_count", dcount, 2);
    chk_int("held_first_done", d1, 82);
    chk_int("held_second_done", d2, 165);
    chk_vec("held_real", bus.xn_vect_real, dc_e, '1);

    // start pulse at E10 during CALC is ignored
    bus.Xk_vect_real = vecs[2].xr;
    bus.Xk_vect_imag = '0;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.Xk_vect_real = '0;
    dcount = 0; d1 = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 9)  bus.start = 1'b1;
      if (k == 10) bus.start = 1'b0;
      if (bus.done) begin
        dcount++;
        if (dcount == 1) d1 = k;
      end
    end
    chk_int("pulse_done_count", dcount, 1);
    chk_int("pulse_done_at", d1, 82);
    chk_int("pulse_idle_busy", int'(bus.busy), 0);
    chk_vec("pulse_real", bus.xn_vect_real, vecs[2].er, bin_m);
    chk_vec("pulse_imag", bus.xn_vect_imag, vecs[2].ei, bin_m);

    // reset at E40 mid-CALC aborts the frame
    bus.Xk_vect_real = dc_x;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 39; k++) tick();
    rst = 1'b0;
    tick();
    chk_int("midrst_busy", int'(bus.busy), 0);
    chk_int("midrst_done", int'(bus.done), 0);
    chk_vec("midrst_xr", bus.xn_vect_real, '0, '1);
    chk_vec("midrst_xi", bus.xn_vect_imag, '0, '1);
    rst = 1'b1;
    dcount = 0;
    for (int k = 0; k < 120; k++) begin
      tick();
      if (bus.done) dcount++;
    end
    chk_int("midrst_no_done", dcount, 0);
    run_frame(dc_x, '0, lat);
    chk_int("midrst_fresh_latency", lat, 82);
    chk_vec("midrst_fresh_real", bus.xn_vect_real, dc_e, '1);
    chk_vec("midrst_fresh_imag", bus.xn_vect_imag, '0, '1);

    // random frames against a floating inverse DFT, 1 LSB tolerance
    for (int f = 0; f < 200; f++) begin
      rr = {8{$urandom}};
      ri = {8{$urandom}};
      run_frame(rr, ri, lat);
      chk_int($sformatf("rand%0d_latency", f), lat, 82);
      bad_n = -1; gr = 0.0; gi = 0.0;
      for (int n = 0; n < 32; n++) begin
        ref_re = 0.0;
        ref_im = 0.0;
        for (int k = 0; k < 32; k++) begin
          ref_re += real'(comp(rr, k)) * cos_t[(k*n) % 32] - real'(comp(ri, k)) * sin_t[(k*n) % 32];
          ref_im += real'(comp(rr, k)) * sin_t[(k*n) % 32] + real'(comp(ri, k)) * cos_t[(k*n) % 32];
        end
        ref_re = ref_re / 32.0;
        ref_im = ref_im / 32.0;
        if (ref_re > 127.0)  ref_re = 127.0;
        if (ref_re < -128.0) ref_re = -128.0;
        if (ref_im > 127.0)  ref_im = 127.0;
        if (ref_im < -128.0) ref_im = -128.0;
        if (bad_n < 0 &&
            ((real'(comp(bus.xn_vect_real, n)) - ref_re > 1.0) ||
             (ref_re - real'(comp(bus.xn_vect_real, n)) > 1.0) ||
             (real'(comp(bus.xn_vect_imag, n)) - ref_im > 1.0) ||
             (ref_im - real'(comp(bus.xn_vect_imag, n)) > 1.0))) begin
          bad_n = n;
          gr = ref_re;
          gi = ref_im;
        end
      end
      n_cmp++;
      if (bad_n >= 0) begin
        n_bad++;
        $display("FAIL rand%0d_x%0d: got (%0d,%0d), expected (%f,%f) within 1 LSB", f, bad_n,
                 comp(bus.xn_vect_real, bad_n), comp(bus.xn_vect_imag, bad_n), gr, gi);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
